prio_arbiter: RTL and testbench
===============================

# prio_arbiter

Parametrised, registered N-way priority arbiter, successor to the 8-bit combinational priority encoder. Samples a request vector every cycle and issues a registered one-hot grant plus binary index. Grant is held while the owner keeps requesting, bounded by an optional hold limit, with fixed-priority or round-robin selection. Sits between N bus masters and one shared resource port.

## Interface
- `N`, 8: number of requesters; legal range 2..32.
- `IDX_W`, `$clog2(N)`: width of grant index.
- `MAX_HOLD`, 0: maximum consecutive grant cycles per ownership; 0 means unlimited. Legal range 0..255.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  request vector; bit N-1 is highest fixed priority.
- `rr_en`  in  1  1 = round-robin selection, 0 = fixed priority; sampled each arbitration.
- `gnt`  out  N  registered one-hot grant; all-zero when no owner.
- `gnt_idx`  out  IDX_W  binary index of owner; 0 when no owner.
- `gnt_vld`  out  1  high when `gnt` is non-zero.
- `idle`  out  1  registered; high when no owner and no request was pending at the last edge.

## Operation
- States: IDLE (no owner) and OWN (one owner `own`, hold counter `hcnt`).
- IDLE: if `|req`, pick winner, go OWN, `hcnt`=1. Else stay IDLE, `idle`=1.
- OWN, `req[own]`=1 and (`MAX_HOLD`=0 or `hcnt`<`MAX_HOLD`): keep owner, `hcnt`++ (saturating at 255).
- OWN, `req[own]`=0: re-arbitrate over `req` in the same edge; a winner is granted directly with no dead cycle. With no requests, go IDLE.
- OWN, hold limit reached: re-arbitrate with `req[own]` masked. If another winner exists, switch to it. Otherwise regrant the same owner with `hcnt`=1.
- Fixed priority: highest set index wins, matching the legacy encoder.
- Round-robin: pointer `last` holds the most recent winner's index. Search order is `last`-1, `last`-2, …, wrapping from 0 to N-1, and ends with `last` itself. `last` updates on every new grant, including a regrant.
- `idle` = 1 only when IDLE and `req` was all-zero at the edge. A pending request clears it in the same edge the grant is issued.
- Requests may drop at any time. Dropping a non-owner request has no effect.

## Timing
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `idle`=1, state IDLE, `last`=0, `hcnt`=0.
- Reset assertion clears all outputs immediately (asynchronous). Deassertion takes effect at the first rising edge after release.
- Latency: request at edge t gives grant visible after edge t; `gnt` is valid in cycle t+1.
- Owner release: `req[own]` low at edge t means the old grant drops and the new grant appears together after edge t.
- A `MAX_HOLD`=M owner holds `gnt` for exactly M cycles when a competitor is pending.
- `rr_en` change takes effect at the next arbitration, never mid-ownership. `last` keeps tracking winners in both modes.

## Configuration
- `PRIO_ARB_RR_EN` defined: round-robin logic and the `last` pointer are compiled in, and `rr_en` selects the mode.
- `PRIO_ARB_RR_EN` undefined: fixed priority only. The `rr_en` port remains but is ignored, and no pointer register is built.

## Structure
- Package `prio_arb_pkg` holds:
  - state enum (`ARB_IDLE`, `ARB_OWN`);
  - hold-counter width constant (8);
  - function `rotate_mask` for the round-robin search.
- Sub-module `prio_pick`: combinational, parameter N. Maps an N-bit vector to a one-hot highest-index pick plus a `none` flag. It is the generalised legacy encoder.
- Round-robin reuses `prio_pick` on the rotated request vector, then un-rotates the result.

## Test plan
- Reset: drive `req`=8'hFF with `rst_n`=0. Expect `gnt`=0, `idle`=1. Release reset; after the first edge expect `gnt`=8'h80, `gnt_idx`=7.
- Fixed priority, `rr_en`=0: `req`=8'h05 gives `gnt`=8'h04. Drop bit 2 to get `req`=8'h01; `gnt`=8'h01 on the next cycle with no zero-grant gap.
- Round-robin, `rr_en`=1, `req`=8'h91 held, owner releases each cycle. Expect grant sequence idx 7, 4, 0, 7.
- Hold limit, `MAX_HOLD`=3: `req`=8'h03 held. Bit 1 is granted for exactly 3 cycles, then bit 0. With `req`=8'h02 only, bit 1 is regranted continuously.
- Mid-operation reset: `rst_n` pulled low while `gnt`=8'h10. `gnt` is 0 before the next edge, and round-robin restarts from `last`=0.
- Compile without `PRIO_ARB_RR_EN`: `rr_en`=1 with `req`=8'h91 always grants idx 7 first.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared types, constants and rotate helper for prio_arbiter
//
// Contents:
//   arb_state_e  : arbiter state (ARB_IDLE, ARB_OWN)
//   HCNT_W       : hold-counter width (8)
//   HCNT_MAX     : hold-counter saturation value
//   MAX_N        : widest request vector supported (32)
//   rotate_mask  : circular right rotation of the low n bits of a MAX_N-bit vector
package prio_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int HCNT_W = 8;
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

    localparam int MAX_N   = 32;
    localparam int MAX_N_W = 5;

    // out[k] = vec[(k + amt) % n] for k < n; bits at or above n are zero.
    // Rotating right by the round-robin pointer places the requester just
    // below the pointer at the top bit, so a highest-index pick on the
    // rotated vector follows the round-robin search order. Rotating right by
    // (n - amt) % n undoes the rotation.
    function automatic logic [MAX_N-1:0] rotate_mask(
        input logic [MAX_N-1:0] vec,
        input int               n,
        input int               amt
    );
        logic [MAX_N-1:0] r;
        int               idx;
        r = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx  = (k + amt) % n;
                r[k] = vec[idx[MAX_N_W-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_arbiter_pick.sv
// rtl/prio_arbiter_pick.sv - combinational highest-index one-hot picker
//
// Module prio_pick, the generalised form of the legacy 8-bit priority encoder.
// Parameters:
//   N    : vector width
// Ports:
//   vec  in  N  candidate vector
//   pick out N  one-hot of the highest set bit of vec; zero when vec is zero
//   none out 1  high when vec is all-zero
module prio_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] pick,
    output logic         none
);

    // Ascending scan: a later (higher) set bit overwrites any earlier one.
    always_comb begin
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    assign none = ~|vec;

endmodule

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-way priority arbiter with hold limit
//
// Build option: define PRIO_ARB_RR_EN to compile in round-robin selection and
// the last-winner pointer; otherwise only fixed priority is built and rr_en
// is ignored.
// Parameters:
//   N        : requesters (2..32)
//   IDX_W    : grant index width
//   MAX_HOLD : max consecutive grant cycles per ownership, 0 = unlimited
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      asynchronous active-low reset
//   req      in  N      request vector, bit N-1 highest fixed priority
//   rr_en    in  1      1 = round-robin, 0 = fixed priority
//   gnt      out N      registered one-hot grant
//   gnt_idx  out IDX_W  owner index, 0 when no owner
//   gnt_vld  out 1      high while gnt is non-zero
//   idle     out 1      no owner and no request at the last edge
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             idle
);

    arb_state_e        state, state_n;
    logic [N-1:0]      gnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic [HCNT_W-1:0] hcnt, hcnt_n;

    logic [N-1:0]      cand;
    logic [N-1:0]      fix_pick;
    logic              fix_none;
    logic [N-1:0]      win;
    logic              win_any;
    logic [IDX_W-1:0]  win_idx;
    logic              own_req;
    logic              hold_hit;
    logic              take;

    assign own_req  = |(req & gnt);
    assign hold_hit = (MAX_HOLD != 0) && (int'(hcnt) >= MAX_HOLD);

    // Masking the current owner is only needed at the hold limit, but it is
    // harmless elsewhere: in IDLE gnt is zero, and on release req[own] is
    // already zero. The keep-owner case never looks at the pick.
    assign cand = req & ~gnt;

    prio_pick #(.N(N)) u_fix_pick (
        .vec  (cand),
        .pick (fix_pick),
        .none (fix_none)
    );

`ifdef PRIO_ARB_RR_EN
    logic [IDX_W-1:0] last, last_n;
    logic [N-1:0]     rot_cand;
    logic [N-1:0]     rot_pick;
    logic             rot_none;
    logic [N-1:0]     rr_pick;

    assign rot_cand = N'(rotate_mask(MAX_N'(cand), N, int'(last)));

    prio_pick #(.N(N)) u_rr_pick (
        .vec  (rot_cand),
        .pick (rot_pick),
        .none (rot_none)
    );

    assign rr_pick = N'(rotate_mask(MAX_N'(rot_pick), N, (N - int'(last)) % N));
    assign win     = rr_en ? rr_pick : fix_pick;
    assign win_any = rr_en ? ~rot_none : ~fix_none;
`else
    logic unused_rr_en;
    assign unused_rr_en = rr_en;
    assign win          = fix_pick;
    assign win_any      = ~fix_none;
`endif

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        hcnt_n  = hcnt;
        take    = 1'b0;
`ifdef PRIO_ARB_RR_EN
        last_n  = last;
`endif
        case (state)
            ARB_IDLE: begin
                take = win_any;
            end
            ARB_OWN: begin
                if (own_req && !hold_hit) begin
                    hcnt_n = (hcnt == HCNT_MAX) ? hcnt : hcnt + HCNT_W'(1);
                end else if (win_any) begin
                    take = 1'b1;
                end else if (own_req) begin
                    // Hold limit reached with no competitor: regrant in place.
                    hcnt_n = HCNT_W'(1);
`ifdef PRIO_ARB_RR_EN
                    last_n = gnt_idx;
`endif
                end else begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                    idx_n   = '0;
                    hcnt_n  = '0;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
        if (take) begin
            state_n = ARB_OWN;
            gnt_n   = win;
            idx_n   = win_idx;
            hcnt_n  = HCNT_W'(1);
`ifdef PRIO_ARB_RR_EN
            last_n  = win_idx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            idle    <= 1'b1;
            hcnt    <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            gnt_vld <= (state_n == ARB_OWN);
            idle    <= ~|req;
            hcnt    <= hcnt_n;
        end
    end

`ifdef PRIO_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
        end else begin
            last <= last_n;
        end
    end
`endif

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - self-checking bench for prio_arbiter (MAX_HOLD 0 and 3)
module tb_prio_arbiter;

    localparam int N = 8;

`ifdef PRIO_ARB_RR_EN
    localparam bit RR_BUILT = 1'b1;
`else
    localparam bit RR_BUILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rr_en;
    logic [N-1:0] req;

    logic [N-1:0] g0, g3;
    logic [2:0]   i0, i3;
    logic         v0, v3, d0, d3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_arbiter #(.N(N), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(g0), .gnt_idx(i0), .gnt_vld(v0), .idle(d0)
    );

    prio_arbiter #(.N(N), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(g3), .gnt_idx(i3), .gnt_vld(v3), .idle(d3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference search: round-robin walks last-1, last-2, ... wrapping, and
    // ends at last; fixed priority walks from N-1 down. excl is skipped.
    function automatic int model_pick(logic [N-1:0] r, int excl, bit rr, int last);
        if (rr) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last - k + N) % N;
                if (r[i] && i != excl) return i;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i] && i != excl) return i;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rr_en = 1'b0;
        req   = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", g0); end
        checks++; if (d0 !== 1'b1)  begin errors++; $display("FAIL reset_idle: got %b expected 1", d0); end
        checks++; if (v0 !== 1'b0)  begin errors++; $display("FAIL reset_vld: got %b expected 0", v0); end
        checks++; if (g3 !== 8'h00) begin errors++; $display("FAIL reset_gnt3: got %h expected 00", g3); end
        rst_n = 1'b1;
        tick();
        checks++; if (g0 !== 8'h80) begin errors++; $display("FAIL reset_first_gnt: got %h expected 80", g0); end
        checks++; if (i0 !== 3'd7)  begin errors++; $display("FAIL reset_first_idx: got %0d expected 7", i0); end
        checks++; if (d0 !== 1'b0)  begin errors++; $display("FAIL reset_first_idle: got %b expected 0", d0); end
    endtask

    task automatic test_fixed();
        apply_reset();
        rr_en = 1'b0;
        req   = 8'h05;
        tick();
        checks++; if (g0 !== 8'h04) begin errors++; $display("FAIL fixed_05: got %h expected 04", g0); end
        checks++; if (i0 !== 3'd2)  begin errors++; $display("FAIL fixed_05_idx: got %0d expected 2", i0); end
        req = 8'h01;
        tick();
        checks++; if (g0 !== 8'h01) begin errors++; $display("FAIL fixed_release: got %h expected 01", g0); end
        checks++; if (v0 !== 1'b1)  begin errors++; $display("FAIL fixed_release_vld: got %b expected 1", v0); end
        req = 8'h00;
        tick();
        checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL fixed_drop_gnt: got %h expected 00", g0); end
        checks++; if (d0 !== 1'b1)  begin errors++; $display("FAIL fixed_drop_idle: got %b expected 1", d0); end
        checks++; if (i0 !== 3'd0)  begin errors++; $display("FAIL fixed_drop_idx: got %0d expected 0", i0); end
    endtask

    task automatic test_round_robin();
        int exp_seq[3];
        if (RR_BUILT) exp_seq = '{4, 0, 7};
        else          exp_seq = '{4, 7, 4};
        apply_reset();
        rr_en = 1'b1;
        req   = 8'h91;
        tick();
        checks++; if (i0 !== 3'd7) begin errors++; $display("FAIL rr_first: got %0d expected 7", i0); end
        for (int k = 0; k < 3; k++) begin
            req = 8'h91 & ~g0;
            tick();
            checks++;
            if (int'(i0) !== exp_seq[k]) begin
                errors++;
                $display("FAIL rr_step%0d: got %0d expected %0d", k, i0, exp_seq[k]);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [N-1:0] exp3[7];
        exp3 = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
        apply_reset();
        rr_en = 1'b0;
        req   = 8'h03;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (g3 !== exp3[k]) begin errors++; $display("FAIL hold3_cyc%0d: got %h expected %h", k, g3, exp3[k]); end
            checks++;
            if (g0 !== 8'h02) begin errors++; $display("FAIL hold0_cyc%0d: got %h expected 02", k, g0); end
        end
        req = 8'h02;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (g3 !== 8'h02 || v3 !== 1'b1) begin
                errors++;
                $display("FAIL hold_regrant_cyc%0d: got %h/%b expected 02/1", k, g3, v3);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        rr_en = 1'b1;
        req   = 8'h10;
        tick();
        checks++; if (g0 !== 8'h10) begin errors++; $display("FAIL midrst_setup: got %h expected 10", g0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL midrst_async_gnt: got %h expected 00", g0); end
        checks++; if (v0 !== 1'b0)  begin errors++; $display("FAIL midrst_async_vld: got %b expected 0", v0); end
        checks++; if (d0 !== 1'b1)  begin errors++; $display("FAIL midrst_async_idle: got %b expected 1", d0); end
        req = 8'h91;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (i0 !== 3'd7) begin errors++; $display("FAIL midrst_rr_restart: got %0d expected 7", i0); end
    endtask

    task automatic test_random();
        int own[2], hc[2], lst[2], mh[2];
        logic [N-1:0] dg;
        logic [2:0]   di;
        logic         dv, dd;
        logic [N-1:0] eg;
        int           w;
        bit           rr;
        mh[0] = 0;
        mh[1] = 3;
        for (int m = 0; m < 2; m++) begin
            own[m] = -1; hc[m] = 0; lst[m] = 0;
        end
        apply_reset();
        rr_en = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            case ($urandom_range(0, 3))
                0: req = N'($urandom_range(0, 255));
                1: req = req & N'($urandom_range(0, 255));
                2: req = req | (N'(1) << $urandom_range(0, N - 1));
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) req = '0;
            if ($urandom_range(0, 9) == 0) rr_en = ~rr_en;
            tick();
            rr = RR_BUILT && rr_en;
            for (int m = 0; m < 2; m++) begin
                if (own[m] < 0) begin
                    w = model_pick(req, -1, rr, lst[m]);
                    if (w >= 0) begin own[m] = w; hc[m] = 1; lst[m] = w; end
                end else if (req[own[m]] && (mh[m] == 0 || hc[m] < mh[m])) begin
                    hc[m] = (hc[m] < 255) ? hc[m] + 1 : 255;
                end else if (!req[own[m]]) begin
                    w = model_pick(req, -1, rr, lst[m]);
                    if (w >= 0) begin own[m] = w; hc[m] = 1; lst[m] = w; end
                    else begin own[m] = -1; hc[m] = 0; end
                end else begin
                    w = model_pick(req, own[m], rr, lst[m]);
                    if (w >= 0) begin own[m] = w; hc[m] = 1; lst[m] = w; end
                    else begin hc[m] = 1; lst[m] = own[m]; end
                end
                if (m == 0) begin dg = g0; di = i0; dv = v0; dd = d0; end
                else        begin dg = g3; di = i3; dv = v3; dd = d3; end
                eg = (own[m] >= 0) ? (N'(1) << own[m]) : '0;
                checks++;
                if (dg !== eg || int'(di) !== ((own[m] >= 0) ? own[m] : 0) ||
                    dv !== (own[m] >= 0) || dd !== (req == '0)) begin
                    errors++;
                    $display("FAIL random_dut%0d_cyc%0d: got gnt=%h idx=%0d vld=%b idle=%b expected gnt=%h idx=%0d vld=%b idle=%b",
                             mh[m], cyc, dg, di, dv, dd, eg, (own[m] >= 0) ? own[m] : 0,
                             (own[m] >= 0), (req == '0));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rr_en = 1'b0;
        req   = '0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold_limit();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
